// File: rtl/asmi_pkg.sv
// Shared types and constants for the ASMI flash arbiter.
// Op encodings, FSM state enum, flash bounds and a bit-reverse helper.
package asmi_pkg;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_ERASE   = 2'd1;
  localparam logic [1:0] OP_PROGRAM = 2'd2;

  localparam logic [23:0] FLASH_TOP = 24'h1FFFFF;

  typedef enum logic [3:0] {
    IDLE,
    ERASE_CMD,
    PROG_SHIFT,
    PROG_WRITE,
    READ_CMD,
    READ_DATA,
    BUSY_WAIT,
    DONE,
    ERR
  } state_t;

  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    for (int i = 0; i < 8; i++) bitrev8[i] = d[7-i];
  endfunction

endpackage

// File: rtl/asmi_rr_arb.sv
// Two-way round-robin selector.
// Ports: i_req (2 requests), i_last (last served), o_valid, o_sel (index).
module asmi_rr_arb
  import asmi_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_sel
);

  assign o_valid = |i_req;

  always_comb begin
    o_sel = 1'b0;
    unique case (1'b1)
      (i_req == 2'b11): o_sel = ~i_last;
      (i_req == 2'b10): o_sel = 1'b1;
      default:          o_sel = 1'b0;
    endcase
  end

endmodule

// File: rtl/asmi_flash_arbiter.sv
// Shares one ASMI EPCS16 controller between two clients.
// Ports: req/op/addr/len per client, gnt/done/err, wr/rd byte paths, ASMI strobes.
module asmi_flash_arbiter
  import asmi_pkg::*;
#(
  parameter int unsigned PAGE_BYTES    = 256,
  parameter logic [23:0] PROTECT_LIMIT = 24'h100000,
  parameter logic [25:0] BUSY_TIMEOUT  = 26'd50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [23:0] addr0,
  input  logic [23:0] addr1,
  input  logic [8:0]  len0,
  input  logic [8:0]  len1,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  input  logic [7:0]  wr_data,
  output logic        wr_rdreq,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [23:0] asmi_addr,
  output logic        asmi_wren,
  output logic        asmi_sector_erase,
  output logic        asmi_write,
  output logic        asmi_shift_bytes,
  output logic        asmi_read,
  output logic        asmi_rden,
  output logic [7:0]  asmi_datain,
  input  logic [7:0]  asmi_dataout,
  input  logic        asmi_busy,
  input  logic        asmi_data_valid
);

  localparam logic [8:0] PB = 9'(PAGE_BYTES);

  state_t      r_state;
  state_t      w_next;
  logic        r_g;
  logic        r_last;
  logic [23:0] r_addr;
  logic [8:0]  r_len;
  logic [8:0]  r_bcnt;
  logic [25:0] r_tmo;
  logic        r_shift;
  logic [7:0]  r_rd_data;
  logic        r_rd_valid;

  logic        w_valid;
  logic        w_sel;
  logic [1:0]  w_op;
  logic [23:0] w_addr;
  logic [8:0]  w_len;
  logic        w_bad;
  logic [1:0]  w_onehot;
  logic        w_rd_beat;

  asmi_rr_arb u_arb (
    .i_req   (req),
    .i_last  (r_last),
    .o_valid (w_valid),
    .o_sel   (w_sel)
  );

  assign w_op   = w_sel ? op1   : op0;
  assign w_addr = w_sel ? addr1 : addr0;
  assign w_len  = w_sel ? len1  : len0;

  assign w_bad = (w_op == 2'd3)
              || ((w_op != OP_READ) && (w_addr < PROTECT_LIMIT))
              || ((w_op == OP_READ) && ((w_len == 9'd0) || (w_len > PB)));

  assign w_onehot  = r_g ? 2'b10 : 2'b01;
  assign w_rd_beat = (r_state == READ_DATA) && asmi_data_valid;

  // Grant is held from selection through the DONE/ERR pulse.
  assign gnt  = (r_state != IDLE) ? w_onehot : 2'b00;
  assign done = (r_state == DONE) ? w_onehot : 2'b00;
  assign err  = (r_state == ERR)  ? w_onehot : 2'b00;

  assign asmi_addr        = (r_state != IDLE) ? r_addr : 24'h0;
  assign asmi_shift_bytes = r_shift;
  assign asmi_datain      = r_shift ? bitrev8(wr_data) : 8'h00;
  assign rd_data          = r_rd_data;
  assign rd_valid         = r_rd_valid;

  always_comb begin
    w_next            = r_state;
    wr_rdreq          = 1'b0;
    asmi_wren         = 1'b0;
    asmi_sector_erase = 1'b0;
    asmi_write        = 1'b0;
    asmi_read         = 1'b0;
    asmi_rden         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_valid) begin
          if (w_bad)                    w_next = ERR;
          else if (w_op == OP_READ)     w_next = READ_CMD;
          else if (w_op == OP_ERASE)    w_next = ERASE_CMD;
          else                          w_next = PROG_SHIFT;
        end
      end
      ERASE_CMD: begin
        asmi_wren         = 1'b1;
        asmi_sector_erase = 1'b1;
        w_next            = BUSY_WAIT;
      end
      PROG_SHIFT: begin
        // One extra cycle after the last pop lets the
        // delayed shift strobe catch the final FIFO byte.
        asmi_wren = 1'b1;
        wr_rdreq  = (r_bcnt != PB);
        if (r_bcnt == PB) w_next = PROG_WRITE;
      end
      PROG_WRITE: begin
        asmi_wren  = 1'b1;
        asmi_write = 1'b1;
        w_next     = BUSY_WAIT;
      end
      READ_CMD: begin
        asmi_read = 1'b1;
        asmi_rden = 1'b1;
        w_next    = READ_DATA;
      end
      READ_DATA: begin
        asmi_rden = 1'b1;
        if (asmi_data_valid && (r_bcnt + 9'd1 == r_len))
          w_next = BUSY_WAIT;
      end
      BUSY_WAIT: begin
        // ASMI raises busy a couple of clocks late.
        if (r_tmo >= 26'd2) begin
          if (!asmi_busy)                 w_next = DONE;
          else if (r_tmo == BUSY_TIMEOUT) w_next = ERR;
        end
      end
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_g        <= 1'b0;
      r_last     <= 1'b1;
      r_addr     <= 24'h0;
      r_len      <= 9'd0;
      r_bcnt     <= 9'd0;
      r_tmo      <= 26'd0;
      r_shift    <= 1'b0;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_shift    <= wr_rdreq;
      r_rd_valid <= w_rd_beat;
      if (w_rd_beat) r_rd_data <= bitrev8(asmi_dataout);
      if ((r_state == IDLE) && w_valid) begin
        r_g    <= w_sel;
        r_len  <= w_len;
        r_addr <= (w_op == OP_PROGRAM) ? {w_addr[23:8], 8'h00}
                                       : w_addr;
      end
      if (r_state == IDLE)              r_bcnt <= 9'd0;
      else if (wr_rdreq || w_rd_beat)   r_bcnt <= r_bcnt + 9'd1;
      if (r_state != BUSY_WAIT)         r_tmo <= 26'd0;
      else if (r_tmo != BUSY_TIMEOUT)   r_tmo <= r_tmo + 26'd1;
      if ((r_state == DONE) || (r_state == ERR)) r_last <= r_g;
    end
  end

endmodule

// File: doc/asmi_flash_arbiter.md
Name: asmi_flash_arbiter

Overview:
- Owns the ASMI EPCS16 serial-flash controller and shares it between two requesters:
  - client 0: PC-driven erase/program path.
  - client 1: config reader fetching settings (MAC/IP) from flash.
- Converts word-level requests (sector erase, 256-byte page program, N-byte read) into ASMI primitive strobes, polls busy, pulses per-client completion.
- Enforces write protection of the factory image region.

Parameters:
- PAGE_BYTES, 256, bytes per page program.
- PROTECT_LIMIT, 24'h100000, erase/program addresses below this are rejected.
- BUSY_TIMEOUT, 26'd50_000_000, clocks allowed in busy wait before error.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  2  request per client, held until done/err.
- op0, op1  in  2 each  per-client op: 0 READ, 1 ERASE, 2 PROGRAM, 3 reserved.
- addr0, addr1  in  24 each  flash byte address.
- len0, len1  in  9 each  read length 1..256; ignored otherwise.
- gnt  out  2  one-hot grant, held for the whole operation.
- done  out  2  1-cycle completion pulse per client.
- err  out  2  1-cycle error pulse per client, in place of done.
- wr_data  in  8  program byte from the granted client's FIFO, MSB-first.
- wr_rdreq  out  1  pop strobe to the granted client's FIFO.
- rd_data  out  8  read byte, MSB-first.
- rd_valid  out  1  rd_data qualifier.
- asmi_addr  out  24  to ASMI addr.
- asmi_wren, asmi_sector_erase, asmi_write, asmi_shift_bytes, asmi_read, asmi_rden  out  1 each  ASMI strobes.
- asmi_datain  out  8  bit-reversed wr_data.
- asmi_dataout  in  8  ASMI read data (LSB-first).
- asmi_busy, asmi_data_valid  in  1 each  ASMI status.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant=1, so client 0 wins the first tie.
- Arbitration in IDLE:
  - Single request: grant it.
  - Both requesting: grant the client not equal to last_grant (round-robin).
  - gnt asserts the cycle after selection; address, op and len are latched at grant.
- No preemption. A req drop mid-operation is ignored; the op completes.
- Protection check at grant: ERASE/PROGRAM with addr < PROTECT_LIMIT, op==3, or READ with len==0 or len>256 goes to ERR. No ASMI strobe is issued.
- ERASE:
  - ERASE_CMD: asmi_wren=1 and asmi_sector_erase=1 for exactly 1 cycle.
  - Then BUSY_WAIT.
- PROGRAM:
  - PROG_SHIFT: asmi_wren=1 throughout.
  - wr_rdreq=1 for PAGE_BYTES consecutive cycles.
  - asmi_shift_bytes=1 one cycle later, aligned with FIFO data (1-cycle FIFO latency).
  - asmi_datain = bit-reverse(wr_data).
  - PROG_WRITE: asmi_write=1 for 1 cycle, then BUSY_WAIT.
  - Address low byte is forced to 0 (page aligned).
- READ:
  - READ_CMD: asmi_read=1 and asmi_rden=1 for 1 cycle.
  - READ_DATA: asmi_rden held until len bytes have been flagged by asmi_data_valid.
  - rd_data = bit-reverse(asmi_dataout); rd_valid mirrors asmi_data_valid, registered with 1-cycle latency.
  - Drop rden; wait for !asmi_busy, then DONE.
- BUSY_WAIT:
  - Waits 2 cycles minimum before sampling asmi_busy (ASMI busy rise latency).
  - Leaves on !asmi_busy, to DONE.
  - Timeout counter reaching BUSY_TIMEOUT goes to ERR.
- DONE/ERR: pulse done[g] or err[g] for 1 cycle, drop gnt, set last_grant=g, return to IDLE.
  - A new grant is not allowed in the same cycle, so at least 1 idle cycle separates grants.
- Byte counter is 9 bits and terminates at count==PAGE_BYTES or count==len. No wrap.
- Reset mid-operation: all strobes deassert immediately. An in-flight flash operation is abandoned; clients must re-request.

Decomposition:
- Shared package asmi_pkg holds:
  - op encodings OP_READ/OP_ERASE/OP_PROGRAM.
  - state enum IDLE, ERASE_CMD, PROG_SHIFT, PROG_WRITE, READ_CMD, READ_DATA, BUSY_WAIT, DONE, ERR.
  - FLASH_TOP=24'h1FFFFF.
- One natural sub-module: asmi_rr_arb, a 2-way round-robin selector.
- The ASMI megafunction is instantiated by the parent, not inside this block.

Test Plan:
- Client 0 ERASE at 24'h100000 → single-cycle wren+sector_erase, busy held 100 cycles, done[0] exactly 1 cycle after busy falls.
- Client 0 PROGRAM at 24'h100000 with bytes 0x01..0xFF,0x00:
  - Exactly 256 wr_rdreq cycles and 256 shift_bytes cycles.
  - First asmi_datain=0x80.
  - One asmi_write pulse, then done[0].
- Client 1 READ len=6 at 24'h1F0000, model returns 0x80,0x40,... LSB-first → rd_data 0x01,0x02,... with 6 rd_valid pulses, then done[1].
- Both req rising in the same cycle after reset → client 0 granted first, client 1 next; a second tie grants client 1 first.
- ERASE at 24'h0F0000 or READ len=0 → err pulse, no ASMI strobe observed.
- busy stuck high with BUSY_TIMEOUT=1000 → err at cycle ~1000.
- reset_n low mid-PROG_SHIFT → all outputs 0 within the same cycle; state IDLE after release.
